// File: rtl/pio_in_edge_irq_pkg.sv
// Shared constants for the edge-capturing input PIO: register word
// addresses and the width of the Avalon data bus.
package pio_in_pkg;

   localparam int BUS_W = 32;

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
   localparam logic [2:0] ADDR_DB_LIMIT = 3'd5;
   localparam logic [2:0] ADDR_RAW      = 3'd6;

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus of the input PIO.
// Handshake: there is no valid/ready pair and no wait state. A write is
// accepted on every rising clk edge where chipselect && !write_n. A read is
// implicit: readdata always shows the register selected by address on the
// previous cycle, whether or not chipselect was asserted, and reading never
// changes any state.
interface pio_in_edge_irq_if;
   import pio_in_pkg::*;

   logic [2:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [BUS_W-1:0] writedata;
   logic [BUS_W-1:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/pio_in_edge_irq_debounce_chan.sv
// One input channel: metastability synchroniser, counter-based debounce
// and single-cycle rise/fall pulses derived from the debounced level.
module pio_debounce_chan #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            async_in,
   input  logic [DB_W-1:0] db_limit,
   output logic            sync_out,
   output logic            stable,
   output logic            rise,
   output logic            fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [DB_W-1:0]        cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   stable_prev_q;
   logic                   sync_bit;

   assign sync_bit = sync_q[SYNC_STAGES-1];

   // Next state: shift the synchroniser; count consecutive mismatches and
   // adopt the synchronised level once it has outlasted db_limit.
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], async_in};
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync_bit == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q < db_limit) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         stable_d = sync_bit;
         cnt_d    = '0;
      end
   end

   // State registers; reset discards any debounce in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q        <= '0;
         cnt_q         <= '0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
      end else begin
         sync_q        <= sync_d;
         cnt_q         <= cnt_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
      end
   end

   assign sync_out = sync_bit;
   assign stable   = stable_q;
   assign rise     = stable_q & ~stable_prev_q;
   assign fall     = ~stable_q & stable_prev_q;

endmodule

// File: rtl/pio_in_edge_irq.sv
// Parametrised input PIO: per-bit synchronise and debounce, selectable
// rising/falling edge capture, write-1-to-clear capture register and a
// masked level interrupt.
module pio_in_edge_irq
   import pio_in_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DB_W        = 16,
   parameter int DB_RESET    = 0
) (
   input  logic             clk,
   input  logic             reset,
   pio_in_edge_irq_if.slave bus,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] sync_w, stable_w, rise_w, fall_w, event_w, clr_w;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [DB_W-1:0]  db_limit_q, db_limit_d;
   logic [BUS_W-1:0] readdata_q, readdata_d;
   logic             wr_en;
   logic             unused_wdata;

   // Write-data bits above the implemented registers are ignored.
   assign unused_wdata = ^bus.writedata;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      pio_debounce_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_W        (DB_W)
      ) u_chan (
         .clk      (clk),
         .reset    (reset),
         .async_in (in_port[gi]),
         .db_limit (db_limit_q),
         .sync_out (sync_w[gi]),
         .stable   (stable_w[gi]),
         .rise     (rise_w[gi]),
         .fall     (fall_w[gi])
      );
   end

   assign wr_en   = bus.chipselect && !bus.write_n;
   assign event_w = (rise_w & rise_en_q) | (fall_w & fall_en_q);
   assign clr_w   = (wr_en && bus.address == ADDR_EDGE_CAP) ?
                    bus.writedata[WIDTH-1:0] : '0;

   // Register writes and capture update; a new event beats a same-cycle clear.
   always_comb begin
      rise_en_d  = rise_en_q;
      irq_mask_d = irq_mask_q;
      fall_en_d  = fall_en_q;
      db_limit_d = db_limit_q;
      edge_cap_d = (edge_cap_q & ~clr_w) | event_w;
      if (wr_en) begin
         case (bus.address)
            ADDR_RISE_EN:  rise_en_d  = bus.writedata[WIDTH-1:0];
            ADDR_IRQ_MASK: irq_mask_d = bus.writedata[WIDTH-1:0];
            ADDR_FALL_EN:  fall_en_d  = bus.writedata[WIDTH-1:0];
            ADDR_DB_LIMIT: db_limit_d = bus.writedata[DB_W-1:0];
            default: ;
         endcase
      end
   end

   // Read mux, zero-extended; registered every cycle regardless of chipselect.
   always_comb begin
      readdata_d = '0;
      case (bus.address)
         ADDR_DATA:     readdata_d[WIDTH-1:0] = stable_w;
         ADDR_RISE_EN:  readdata_d[WIDTH-1:0] = rise_en_q;
         ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
         ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
         ADDR_FALL_EN:  readdata_d[WIDTH-1:0] = fall_en_q;
         ADDR_DB_LIMIT: readdata_d[DB_W-1:0]  = db_limit_q;
         ADDR_RAW:      readdata_d[WIDTH-1:0] = sync_w;
         default: ;
      endcase
   end

   // Bus-visible registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rise_en_q  <= '0;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
         fall_en_q  <= '0;
         db_limit_q <= DB_W'(DB_RESET);
         readdata_q <= '0;
      end else begin
         rise_en_q  <= rise_en_d;
         irq_mask_q <= irq_mask_d;
         edge_cap_q <= edge_cap_d;
         fall_en_q  <= fall_en_d;
         db_limit_q <= db_limit_d;
         readdata_q <= readdata_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Self-checking bench for pio_in_edge_irq: a register table, hand-written
// corner sequences and a randomized phase, all checked every cycle against
// a behavioural model of the PIO.
module tb_pio_in_edge_irq;

   localparam int W    = 4;
   localparam int S    = 2;
   localparam int HIST = 40;

   logic         clk;
   logic         reset;
   logic [W-1:0] in_port;
   logic         irq;
   logic [31:0]  rdat;

   int n_vec;
   int n_miss;

   pio_in_edge_irq_if bus ();

   pio_in_edge_irq #(
      .WIDTH       (W),
      .SYNC_STAGES (S),
      .DB_W        (16),
      .DB_RESET    (0)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .in_port (in_port),
      .irq     (irq)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_pipe [S];
   logic [W-1:0] m_hist [$];   // synchronised samples, newest first
   logic [W-1:0] m_stable, m_prev, m_cap, m_rise, m_fall, m_mask;
   logic [15:0]  m_db;
   logic [31:0]  m_rd;

   // True when the last db+1 synchronised samples of bit b all differ
   // from the current debounced level.
   function automatic bit persisted(int b);
      int need;
      need = int'(m_db) + 1;
      if (m_hist.size() < need) return 1'b0;
      for (int k = 0; k < need; k++)
         if (m_hist[k][b] == m_stable[b]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: advance the model on the rising edge, compare on the
   // falling edge.
   task automatic tick();
      logic [W-1:0] sync_old, ev, clr, nxt;
      logic [31:0]  rd_n;
      logic         wr;
      @(posedge clk);
      wr = bus.chipselect && !bus.write_n;
      if (reset) begin
         for (int i = 0; i < S; i++) m_pipe[i] = '0;
         m_hist.delete();
         m_stable = '0; m_prev = '0; m_cap = '0;
         m_rise = '0; m_fall = '0; m_mask = '0; m_db = '0; m_rd = '0;
      end else begin
         sync_old = m_pipe[S-1];
         rd_n = '0;
         case (bus.address)
            3'd0: rd_n[W-1:0] = m_stable;
            3'd1: rd_n[W-1:0] = m_rise;
            3'd2: rd_n[W-1:0] = m_mask;
            3'd3: rd_n[W-1:0] = m_cap;
            3'd4: rd_n[W-1:0] = m_fall;
            3'd5: rd_n[15:0]  = m_db;
            3'd6: rd_n[W-1:0] = sync_old;
            default: rd_n = '0;
         endcase
         ev  = (m_stable & ~m_prev & m_rise) | (~m_stable & m_prev & m_fall);
         clr = (wr && bus.address == 3'd3) ? bus.writedata[W-1:0] : '0;
         m_hist.push_front(sync_old);
         if (m_hist.size() > HIST) void'(m_hist.pop_back());
         nxt = m_stable;
         for (int b = 0; b < W; b++)
            if (persisted(b)) nxt[b] = sync_old[b];
         m_prev   = m_stable;
         m_stable = nxt;
         m_cap    = (m_cap & ~clr) | ev;
         for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
         m_pipe[0] = in_port;
         if (wr) begin
            case (bus.address)
               3'd1: m_rise = bus.writedata[W-1:0];
               3'd2: m_mask = bus.writedata[W-1:0];
               3'd4: m_fall = bus.writedata[W-1:0];
               3'd5: m_db   = bus.writedata[15:0];
               default: ;
            endcase
         end
         m_rd = rd_n;
      end
      @(negedge clk);
      check("model_readdata", bus.readdata, m_rd);
      check("model_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus.address = a; bus.writedata = d;
      bus.chipselect = 1'b1; bus.write_n = 1'b0;
      tick();
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
      tick();
      d = bus.readdata;
      bus.chipselect = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      check(name, d, exp);
   endtask

   // ---------------- register table ----------------
   typedef struct {
      logic        we;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [17];

   initial begin
      n_vec = 0; n_miss = 0;
      reset = 1'b1; in_port = '0;
      bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;

      tbl[0]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0};
      tbl[1]  = '{1'b0, 3'd1, 32'h0, 32'h0000_000F};
      tbl[2]  = '{1'b1, 3'd2, 32'h0000_00A5, 32'h0};
      tbl[3]  = '{1'b0, 3'd2, 32'h0, 32'h0000_0005};
      tbl[4]  = '{1'b1, 3'd4, 32'h0000_0003, 32'h0};
      tbl[5]  = '{1'b0, 3'd4, 32'h0, 32'h0000_0003};
      tbl[6]  = '{1'b1, 3'd5, 32'h0001_2345, 32'h0};
      tbl[7]  = '{1'b0, 3'd5, 32'h0, 32'h0000_2345};
      tbl[8]  = '{1'b1, 3'd7, 32'h0000_00FF, 32'h0};
      tbl[9]  = '{1'b0, 3'd7, 32'h0, 32'h0};
      tbl[10] = '{1'b0, 3'd0, 32'h0, 32'h0};
      tbl[11] = '{1'b0, 3'd6, 32'h0, 32'h0};
      tbl[12] = '{1'b0, 3'd3, 32'h0, 32'h0};
      tbl[13] = '{1'b1, 3'd3, 32'h0000_000F, 32'h0};
      tbl[14] = '{1'b0, 3'd3, 32'h0, 32'h0};
      tbl[15] = '{1'b1, 3'd0, 32'h0000_000F, 32'h0};
      tbl[16] = '{1'b0, 3'd0, 32'h0, 32'h0};

      // ---- reset ----
      @(negedge clk);
      idle(2);
      reset = 1'b0;
      check("reset_readdata", bus.readdata, 32'h0);
      check("reset_irq", {31'd0, irq}, 32'h0);

      // ---- register table ----
      for (int i = 0; i < 17; i++) begin
         if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
         else           rd_chk($sformatf("table_%0d", i), tbl[i].addr, tbl[i].exp);
      end

      // ---- pass-through rise, irq latency, clear ----
      wr(3'd5, 32'h0); wr(3'd4, 32'h0); wr(3'd1, 32'hF); wr(3'd2, 32'h1);
      in_port = 4'h1;
      idle(3);
      check("irq_before_4", {31'd0, irq}, 32'h0);
      tick();
      check("irq_at_4", {31'd0, irq}, 32'h1);
      rd_chk("data_after_rise", 3'd0, 32'h1);
      rd_chk("cap_after_rise", 3'd3, 32'h1);
      wr(3'd3, 32'h1);
      check("irq_after_clear", {31'd0, irq}, 32'h0);
      rd_chk("cap_after_clear", 3'd3, 32'h0);
      in_port = 4'h0;
      idle(6);

      // ---- debounce: glitch rejected, hold accepted after 13 cycles ----
      wr(3'd5, 32'd10);
      bus.address = 3'd0;
      in_port = 4'h4;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("glitch_data", bus.readdata, 32'h0);
      end
      in_port = 4'h0;
      for (int i = 0; i < 16; i++) begin
         tick();
         check("glitch_settle_data", bus.readdata, 32'h0);
      end
      rd_chk("glitch_no_cap", 3'd3, 32'h0);
      bus.address = 3'd0;
      in_port = 4'h4;
      // DATA changes on edge 13; readdata shows it one edge later.
      for (int k = 1; k <= 14; k++) begin
         tick();
         if (k == 13) check("hold_data_edge13", bus.readdata, 32'h0);
         if (k == 14) check("hold_data_edge14", bus.readdata, 32'h4);
      end
      idle(3);
      rd_chk("hold_cap", 3'd3, 32'h4);
      wr(3'd3, 32'hF);

      // ---- falling-edge only ----
      wr(3'd5, 32'h0);
      in_port = 4'h0;
      idle(6);
      wr(3'd1, 32'h0); wr(3'd4, 32'h2); wr(3'd3, 32'hF);
      in_port = 4'h2;
      idle(6);
      rd_chk("fall_no_cap_on_rise", 3'd3, 32'h0);
      in_port = 4'h0;
      idle(6);
      rd_chk("fall_cap", 3'd3, 32'h2);
      wr(3'd3, 32'hF);

      // ---- set beats same-cycle clear; writing 0 keeps ----
      wr(3'd4, 32'h0); wr(3'd1, 32'h8);
      in_port = 4'h8;
      idle(6);
      rd_chk("preset_cap", 3'd3, 32'h8);
      in_port = 4'h0;
      idle(6);
      in_port = 4'h8;
      idle(3);
      wr(3'd3, 32'h8);       // lands on the edge where the new event captures
      rd_chk("set_wins", 3'd3, 32'h8);
      wr(3'd3, 32'h4);
      rd_chk("write0_keeps", 3'd3, 32'h8);
      wr(3'd3, 32'h8);
      rd_chk("cap_cleared", 3'd3, 32'h0);

      // ---- mask controls irq; unused address; DB_LIMIT readback ----
      wr(3'd1, 32'h5); wr(3'd2, 32'h0);
      in_port = 4'h5;
      idle(6);
      check("masked_irq", {31'd0, irq}, 32'h0);
      rd_chk("cap_0x5", 3'd3, 32'h5);
      wr(3'd2, 32'h4);
      check("unmask_irq", {31'd0, irq}, 32'h1);
      rd_chk("addr7_zero", 3'd7, 32'h0);
      wr(3'd5, 32'h1234);
      rd_chk("db_limit_rb", 3'd5, 32'h1234);

      // ---- reset in the middle of a debounce count ----
      wr(3'd5, 32'd10); wr(3'd3, 32'hF); wr(3'd2, 32'hF); wr(3'd1, 32'hF);
      in_port = 4'hF;
      idle(7);
      reset = 1'b1; in_port = 4'h0;
      tick();
      reset = 1'b0;
      check("midreset_readdata", bus.readdata, 32'h0);
      check("midreset_irq", {31'd0, irq}, 32'h0);
      for (int a = 0; a < 8; a++)
         rd_chk($sformatf("midreset_reg%0d", a), 3'(a), 32'h0);
      idle(20);
      rd_chk("midreset_no_spurious", 3'd3, 32'h0);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 600; i++) begin
         logic [2:0] a;
         if ($urandom_range(0, 7) == 0) in_port = W'($urandom);
         reset = ($urandom_range(0, 199) == 0);
         a = 3'($urandom_range(0, 7));
         bus.address = a;
         bus.chipselect = 1'b1;
         if ($urandom_range(0, 3) == 0) begin
            bus.write_n = 1'b0;
            bus.writedata = (a == 3'd5) ? 32'($urandom_range(0, 5)) : $urandom;
         end else begin
            bus.write_n = 1'b1;
            bus.writedata = $urandom;
         end
         tick();
      end
      reset = 1'b0;
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
